// File: rtl/branch_resolve_unit.sv
// Registered MIPS conditional-branch resolver with a PC-indexed 2-bit counter predictor table.
// Optional performance counters are built in when BRU_STATS_EN is defined.
module branch_resolve_unit #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned BHT_DEPTH = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid_i,
  input  logic [5:0]        op_i,
  input  logic [4:0]        rt_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic              pred_taken_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [PC_W-1:0]   lookup_pc_i,
  output logic              lookup_taken_o,
  output logic              valid_o,
  output logic              is_branch_o,
  output logic              taken_o,
  output logic              link_o,
  output logic              mispredict_o,
  output logic [PC_W-1:0]   pc_o
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]       stat_branches_o,
  output logic [31:0]       stat_mispredicts_o
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  localparam logic [5:0] OpRegimm = 6'b000001;
  localparam logic [5:0] OpBeq    = 6'b000100;
  localparam logic [5:0] OpBne    = 6'b000101;
  localparam logic [5:0] OpBlez   = 6'b000110;
  localparam logic [5:0] OpBgtz   = 6'b000111;

  // Combinational decode and compare
  logic a_sign, a_zero, a_eq_b;
  logic dec_branch, dec_taken, dec_link;

  assign a_sign = a_i[DATA_W-1];
  assign a_zero = (a_i == '0);
  assign a_eq_b = (a_i == b_i);

  always_comb begin
    dec_branch = 1'b0;
    dec_taken  = 1'b0;
    dec_link   = 1'b0;
    case (op_i)
      OpBeq: begin
        dec_branch = 1'b1;
        dec_taken  = a_eq_b;
      end
      OpBne: begin
        dec_branch = 1'b1;
        dec_taken  = ~a_eq_b;
      end
      OpBgtz: begin
        dec_branch = 1'b1;
        dec_taken  = ~a_sign & ~a_zero;
      end
      OpBlez: begin
        dec_branch = 1'b1;
        dec_taken  = a_sign | a_zero;
      end
      OpRegimm: begin
        case (rt_i)
          5'b00000, 5'b10000: begin
            dec_branch = 1'b1;
            dec_taken  = a_sign;
            dec_link   = rt_i[4];
          end
          5'b00001, 5'b10001: begin
            dec_branch = 1'b1;
            dec_taken  = ~a_sign;
            dec_link   = rt_i[4];
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Result stage
  logic            valid_q, valid_d;
  logic            branch_q, branch_d;
  logic            taken_q, taken_d;
  logic            link_q, link_d;
  logic            pred_q, pred_d;
  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    valid_d  = valid_q;
    branch_d = branch_q;
    taken_d  = taken_q;
    link_d   = link_q;
    pred_d   = pred_q;
    pc_d     = pc_q;
    if (!stall_i) begin
      if (flush_i) begin
        valid_d  = 1'b0;
        branch_d = 1'b0;
        taken_d  = 1'b0;
        link_d   = 1'b0;
        pred_d   = 1'b0;
        pc_d     = '0;
      end else begin
        valid_d  = valid_i;
        branch_d = valid_i & dec_branch;
        taken_d  = valid_i & dec_taken;
        link_d   = valid_i & dec_link;
        pred_d   = pred_taken_i;
        pc_d     = pc_i;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q  <= 1'b0;
      branch_q <= 1'b0;
      taken_q  <= 1'b0;
      link_q   <= 1'b0;
      pred_q   <= 1'b0;
      pc_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      branch_q <= branch_d;
      taken_q  <= taken_d;
      link_q   <= link_d;
      pred_q   <= pred_d;
      pc_q     <= pc_d;
    end
  end

  assign valid_o      = valid_q;
  assign is_branch_o  = branch_q;
  assign taken_o      = taken_q;
  assign link_o       = link_q;
  assign pc_o         = pc_q;
  assign mispredict_o = valid_q & branch_q & (taken_q != pred_q);

  // Branch history table; word-aligned index, upper PC bits alias
  logic [1:0]       bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             bht_we;
  logic [1:0]       cnt_cur, cnt_d;

  assign wr_idx  = pc_i[IDX_W+1:2];
  assign rd_idx  = lookup_pc_i[IDX_W+1:2];
  assign bht_we  = ~stall_i & ~flush_i & valid_i & dec_branch;
  assign cnt_cur = bht_q[wr_idx];

  always_comb begin
    cnt_d = cnt_cur;
    if (dec_taken) begin
      if (cnt_cur != 2'b11) cnt_d = cnt_cur + 2'd1;
    end else begin
      if (cnt_cur != 2'b00) cnt_d = cnt_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else if (bht_we) begin
      bht_q[wr_idx] <= cnt_d;
    end
  end

  // No bypass: a same-cycle update is visible only after the edge
  assign lookup_taken_o = bht_q[rd_idx][1];

  logic unused_pc;
  assign unused_pc = ^{pc_i[1:0], lookup_pc_i};

`ifdef BRU_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;
  logic        stat_en;

  assign stat_en = valid_q & branch_q & ~stall_i;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (stat_en) begin
      stat_br_d = stat_br_q + 32'd1;
      if (mispredict_o) stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: driver pushes model results, monitor pops and compares.
module tb_branch_resolve_unit;

  logic        clk;
  logic        resetn;
  logic        valid_i;
  logic [5:0]  op_i;
  logic [4:0]  rt_i;
  logic [31:0] a_i, b_i, pc_i, lookup_pc_i;
  logic        pred_taken_i, stall_i, flush_i;
  logic        lookup_taken_o, valid_o, is_branch_o, taken_o, link_o, mispredict_o;
  logic [31:0] pc_o;
`ifdef BRU_STATS_EN
  logic [31:0] stat_branches_o, stat_mispredicts_o;
`endif

  branch_resolve_unit dut (
    .clk            (clk),
    .resetn         (resetn),
    .valid_i        (valid_i),
    .op_i           (op_i),
    .rt_i           (rt_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .pc_i           (pc_i),
    .pred_taken_i   (pred_taken_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .lookup_pc_i    (lookup_pc_i),
    .lookup_taken_o (lookup_taken_o),
    .valid_o        (valid_o),
    .is_branch_o    (is_branch_o),
    .taken_o        (taken_o),
    .link_o         (link_o),
    .mispredict_o   (mispredict_o),
    .pc_o           (pc_o)
`ifdef BRU_STATS_EN
    ,
    .stat_branches_o    (stat_branches_o),
    .stat_mispredicts_o (stat_mispredicts_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        br;
    logic        tk;
    logic        lk;
    logic        mp;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   bht_m[64];
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, got, want);
  endtask

  // Reference: branch outcome from signed arithmetic on the operands
  function automatic void ref_decode(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output bit br, output bit tk, output bit lk);
    int sa;
    sa = $signed(a);
    br = 0; tk = 0; lk = 0;
    if (op == 6'd4)      begin br = 1; tk = (a == b); end
    else if (op == 6'd5) begin br = 1; tk = (a != b); end
    else if (op == 6'd7) begin br = 1; tk = (sa > 0); end
    else if (op == 6'd6) begin br = 1; tk = (sa <= 0); end
    else if (op == 6'd1) begin
      if (rt == 5'd0 || rt == 5'd16)      begin br = 1; tk = (sa < 0);  lk = (rt == 5'd16); end
      else if (rt == 5'd1 || rt == 5'd17) begin br = 1; tk = (sa >= 0); lk = (rt == 5'd17); end
    end
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  task automatic step(input bit v, input logic [5:0] op, input logic [4:0] rt,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                      input bit pred, input bit st, input bit fl, input logic [31:0] lpc);
    exp_t e;
    bit br, tk, lk, upd;
    int ui, nv;
    @(negedge clk);
    valid_i = v; op_i = op; rt_i = rt; a_i = a; b_i = b; pc_i = pc;
    pred_taken_i = pred; stall_i = st; flush_i = fl; lookup_pc_i = lpc;
    #1;
    chk("lookup_taken", {31'd0, lookup_taken_o}, {31'd0, bht_m[idx_of(lpc)] >= 2});
    ref_decode(op, rt, a, b, br, tk, lk);
    upd = 0;
    nv = 0;
    ui = idx_of(pc);
    if (!st) begin
      e = '0;
      if (!fl) begin
        e.valid = v;
        e.br    = v & br;
        e.tk    = v & tk;
        e.lk    = v & lk;
        e.pc    = pc;
        e.mp    = e.valid & e.br & (e.tk != pred);
        if (v && br) begin
          upd = 1;
          nv  = tk ? ((bht_m[ui] < 3) ? bht_m[ui] + 1 : 3) : ((bht_m[ui] > 0) ? bht_m[ui] - 1 : 0);
        end
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (upd) bht_m[ui] = nv;
  endtask

  task automatic idle(input logic [31:0] lpc);
    step(0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, lpc);
  endtask

  task automatic cmp_out(input exp_t e, input string tag);
    chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, e.valid});
    chk({tag, ".is_branch"}, {31'd0, is_branch_o}, {31'd0, e.br});
    chk({tag, ".taken"}, {31'd0, taken_o}, {31'd0, e.tk});
    chk({tag, ".link"}, {31'd0, link_o}, {31'd0, e.lk});
    chk({tag, ".mispredict"}, {31'd0, mispredict_o}, {31'd0, e.mp});
    chk({tag, ".pc"}, pc_o, e.pc);
  endtask

  // Monitor: every unstalled edge delivers the next queued result; stalled edges hold
  initial begin : monitor
    exp_t last, e;
    bit s, r;
    last = '0;
    forever begin
      @(posedge clk);
      s = stall_i;
      r = resetn;
      #1;
      if (!r || !resetn) begin
        exp_q.delete();
        last = '0;
      end else if (s) begin
        cmp_out(last, "hold");
      end else if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        cmp_out(e, "stage");
        last = e;
      end
    end
  end

  task automatic reset_and_sweep();
    stall_i = 1; valid_i = 0; flush_i = 0;
    resetn = 1'b0;
    #1;
    chk("rst.valid", {31'd0, valid_o}, 32'd0);
    chk("rst.is_branch", {31'd0, is_branch_o}, 32'd0);
    chk("rst.taken", {31'd0, taken_o}, 32'd0);
    chk("rst.link", {31'd0, link_o}, 32'd0);
    chk("rst.mispredict", {31'd0, mispredict_o}, 32'd0);
    chk("rst.pc", pc_o, 32'd0);
    for (int i = 0; i < 64; i++) bht_m[i] = 1;
    for (int i = 0; i < 64; i++) begin
      lookup_pc_i = i * 4;
      #1;
      chk("rst.lookup", {31'd0, lookup_taken_o}, 32'd0);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic rand_step();
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] a, b, pc;
    int sel;
    sel = $urandom_range(0, 6);
    case (sel)
      0: op = 6'd4;
      1: op = 6'd5;
      2: op = 6'd6;
      3: op = 6'd7;
      4, 5: op = 6'd1;
      default: op = 6'($urandom);
    endcase
    sel = $urandom_range(0, 4);
    case (sel)
      0: rt = 5'd0;
      1: rt = 5'd1;
      2: rt = 5'd16;
      3: rt = 5'd17;
      default: rt = 5'($urandom);
    endcase
    a = $urandom;
    sel = $urandom_range(0, 3);
    if (sel == 0) a = 32'd0;
    b = (sel == 1) ? a : $urandom;
    pc = {$urandom_range(0, 255), 2'b00};
    step($urandom_range(0, 7) != 0, op, rt, a, b, pc, 1'($urandom),
         $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
         {$urandom_range(0, 255), 2'b00});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    valid_i = 0; op_i = 0; rt_i = 0; a_i = 0; b_i = 0; pc_i = 0;
    pred_taken_i = 0; stall_i = 1; flush_i = 0; lookup_pc_i = 0;
    resetn = 1'b0;
    #2;
    reset_and_sweep();

    // BEQ equal, predicted not-taken
    step(1, 6'd4, 5'd0, 32'h1234, 32'h1234, 32'h100, 0, 0, 0, 32'h100);
    idle(32'h100);
    // REGIMM link forms and a non-branch
    step(1, 6'd1, 5'd16, 32'h8000_0000, 32'd0, 32'h200, 1, 0, 0, 32'h200);
    step(1, 6'd1, 5'd1, 32'h8000_0000, 32'd0, 32'h200, 1, 0, 0, 32'h200);
    step(1, 6'd8, 5'd0, 32'd7, 32'd7, 32'h300, 0, 0, 0, 32'h300);
    idle(32'h300);
    // Saturation up then down
    for (int i = 0; i < 4; i++) step(1, 6'd4, 5'd0, 32'd9, 32'd9, 32'h40, 1, 0, 0, 32'h40);
    for (int i = 0; i < 5; i++) step(1, 6'd5, 5'd0, 32'd9, 32'd9, 32'h40, 0, 0, 0, 32'h40);
    idle(32'h40);
    // Stall / flush interactions
    step(1, 6'd4, 5'd0, 32'd1, 32'd1, 32'h80, 0, 0, 0, 32'h84);
    for (int i = 0; i < 3; i++) step(1, 6'd7, 5'd0, 32'd5, 32'd0, 32'h84, 0, 1, 0, 32'h84);
    step(1, 6'd7, 5'd0, 32'd5, 32'd0, 32'h84, 0, 1, 1, 32'h84);
    step(1, 6'd7, 5'd0, 32'd5, 32'd0, 32'h84, 0, 0, 1, 32'h84);
    idle(32'h84);

    for (int i = 0; i < 400; i++) rand_step();

    // Reset mid-stream after taken branches
    for (int i = 0; i < 3; i++) step(1, 6'd4, 5'd0, 32'd3, 32'd3, 32'h10, 0, 0, 0, 32'h10);
    #2;
    reset_and_sweep();
    for (int i = 0; i < 100; i++) rand_step();
    idle(32'h10);

    #3;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, registered successor to the combinational branch comparator.
- Resolves MIPS conditional branches (BEQ/BNE/BGTZ/BLEZ and the REGIMM BLTZ/BGEZ/BLTZAL/BGEZAL group) at any operand width.
- Registers the outcome for the execute stage and flags mispredicts against the fetch-time prediction.
- Maintains a PC-indexed table of 2-bit saturating counters; fetch reads it through a lookup port.

Parameters:
DATA_W, 32, operand width; sign bit is a_i[DATA_W-1]
PC_W, 32, program counter width
BHT_DEPTH, 64, counter entries; power of two, 2..1024
IDX_W, log2(BHT_DEPTH), derived, index width; not user-set

Ports:
clk  in  1  clock, all state rising-edge
resetn  in  1  asynchronous active-low reset
valid_i  in  1  instruction present at input
op_i  in  6  opcode field
rt_i  in  5  rt field (REGIMM sub-op)
a_i  in  DATA_W  rs operand
b_i  in  DATA_W  rt operand
pc_i  in  PC_W  branch instruction PC
pred_taken_i  in  1  prediction made at fetch
stall_i  in  1  hold stage register
flush_i  in  1  kill incoming instruction
lookup_pc_i  in  PC_W  fetch PC for prediction
lookup_taken_o  out  1  predicted taken for lookup_pc_i
valid_o  out  1  registered result valid
is_branch_o  out  1  registered instruction is a recognised branch
taken_o  out  1  registered branch outcome
link_o  out  1  registered BLTZAL/BGEZAL (write r31)
mispredict_o  out  1  valid_o & is_branch_o & (taken_o != pred_o)
pc_o  out  PC_W  registered PC

Behaviour:
- Opcode decode:
  - op 000100 BEQ: a==b. 000101 BNE: a!=b. 000111 BGTZ: sign==0 & a!=0. 000110 BLEZ: sign==1 | a==0.
  - op 000001 REGIMM: rt 00000 BLTZ / 10000 BLTZAL take sign==1; rt 00001 BGEZ / 10001 BGEZAL take sign==0.
  - Any other op/rt: is_branch=0, taken=0, link=0.
- Comparison is combinational. The result is captured in one register stage, so latency is 1 cycle.
- On resetn low, asynchronously:
  - valid_o, is_branch_o, taken_o, link_o, mispredict_o, pred_o (internal) = 0; pc_o = 0.
  - Every BHT counter = 2'b01 (weakly not-taken).
- Stage load, per rising edge with resetn high:
  - stall_i=1: all registers hold. Takes priority over flush_i. No BHT write.
  - stall_i=0, flush_i=1: valid_o <= 0, other fields don't-care but driven 0. No BHT write.
  - stall_i=0, flush_i=0: valid_o <= valid_i; other fields load from the decode.
  - valid_i=0: is_branch/taken/link load 0.
- BHT index = pc[IDX_W+1:2]; word-aligned, upper bits alias.
- BHT update happens on the same edge as a stage load with valid_i & is_branch & !stall_i & !flush_i.
  - Taken: counter +1, saturating at 3. Not taken: counter -1, saturating at 0.
  - Non-branch instructions never write.
- lookup_taken_o = counter[lookup index][1], combinational.
- Read during a same-cycle write to the same entry returns the pre-update value (no bypass).
- Reset mid-operation discards any in-flight result; no partial BHT write.

Optional Feature:
BRU_STATS_EN:
- Defined: adds outputs stat_branches_o[31:0] and stat_mispredicts_o[31:0], both reset to 0.
  - stat_branches_o increments each cycle where valid_o & is_branch_o & !stall_i.
  - stat_mispredicts_o increments each such cycle where mispredict_o is also 1.
  - Both wrap 0xFFFFFFFF -> 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then sweep lookup_pc_i over 64 entries -> lookup_taken_o=0 everywhere; all outputs 0.
- BEQ a=b=0x1234, pred=0, pc=0x100 -> next cycle valid_o=1, taken_o=1, mispredict_o=1; entry 0 counter becomes 2, so lookup_pc_i=0x100 gives 1.
- REGIMM rt=10000 a=0x80000000, pred=1 -> taken_o=1, link_o=1, mispredict_o=0. Same with rt=00001 -> taken_o=0, mispredict_o=1. Op 001000 -> is_branch_o=0, no BHT change.
- Four consecutive taken BEQ at pc=0x40 -> counter saturates at 3. Five BNE equal operands at the same pc -> saturates at 0, lookup 0.
- stall_i=1 with BGTZ a=5 presented for 3 cycles -> outputs hold prior values, counter unchanged. stall_i and flush_i together -> hold. flush_i alone -> valid_o=0 and no update.
- Assert resetn low for 1 cycle mid-stream after taken branches -> outputs 0 immediately, all counters 01, with no clock edge needed.
